// File: rtl/i_execute.sv
// EX stage of the 5-stage MIPS pipeline: ALU control, operand select, ALU, branch target, EX/MEM register.
// Optional operand forwarding is enabled by defining FORWARD_EN.
module i_execute #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic [1:0]    wb_ctl,
  input  logic [2:0]    m_ctl,
  input  logic [3:0]    ex_ctl,
  input  logic [DW-1:0] npc,
  input  logic [DW-1:0] rdata1,
  input  logic [DW-1:0] rdata2,
  input  logic [DW-1:0] s_extend,
  input  logic [RW-1:0] instr_2016,
  input  logic [RW-1:0] instr_1511,
`ifdef FORWARD_EN
  input  logic [RW-1:0] instr_2521,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
`endif
  output logic [1:0]    wb_ctlout,
  output logic          branch,
  output logic          memread,
  output logic          memwrite,
  output logic [DW-1:0] add_result,
  output logic          zero,
  output logic [DW-1:0] alu_result,
  output logic [DW-1:0] rdata2out,
  output logic [RW-1:0] five_bit_muxout
);

  typedef enum logic [2:0] {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_NONE} alu_op_t;

  logic          regdst, alusrc;
  logic [1:0]    aluop;
  logic [5:0]    funct;
  alu_op_t       alu_op;
  logic [DW-1:0] op_a, op_b, rt_val, alu_next, target_next;
  logic [RW-1:0] dst_next;

  assign regdst = ex_ctl[3];
  assign aluop  = ex_ctl[2:1];
  assign alusrc = ex_ctl[0];
  assign funct  = s_extend[5:0];

  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    alu_op = OP_NONE;
    case (aluop)
      2'b00: alu_op = OP_ADD;
      2'b01: alu_op = OP_SUB;
      2'b11: alu_op = OP_OR;
      default: begin
        case (funct)
          6'b100000: alu_op = OP_ADD;
          6'b100010: alu_op = OP_SUB;
          6'b100100: alu_op = OP_AND;
          6'b100101: alu_op = OP_OR;
          6'b101010: alu_op = OP_SLT;
          default:   alu_op = OP_NONE;
        endcase
      end
    endcase
  end

`ifdef FORWARD_EN
  // EX/MEM wins over MEM/WB because it holds the younger result.
  always_comb begin
    op_a   = rdata1;
    rt_val = rdata2;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == instr_2521)
      op_a = alu_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == instr_2521)
      op_a = memwb_data;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == instr_2016)
      rt_val = alu_result;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == instr_2016)
      rt_val = memwb_data;
  end
`else
  assign op_a   = rdata1;
  assign rt_val = rdata2;
`endif

  assign op_b = alusrc ? s_extend : rt_val;

  always_comb begin
    alu_next = '0;
    case (alu_op)
      OP_ADD:  alu_next = op_a + op_b;
      OP_SUB:  alu_next = op_a - op_b;
      OP_AND:  alu_next = op_a & op_b;
      OP_OR:   alu_next = op_a | op_b;
      OP_SLT:  alu_next = {{(DW-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_next = '0;
    endcase
  end

  assign target_next = npc + {s_extend[DW-3:0], 2'b00};
  assign dst_next    = regdst ? instr_1511 : instr_2016;

  // Flush only has to kill the control bits; data fields of a bubble are don't-care.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      wb_ctlout       <= '0;
      branch          <= 1'b0;
      memread         <= 1'b0;
      memwrite        <= 1'b0;
      add_result      <= '0;
      zero            <= 1'b0;
      alu_result      <= '0;
      rdata2out       <= '0;
      five_bit_muxout <= '0;
    end else if (flush) begin
      wb_ctlout <= '0;
      branch    <= 1'b0;
      memread   <= 1'b0;
      memwrite  <= 1'b0;
    end else if (!stall) begin
      wb_ctlout       <= wb_ctl;
      branch          <= m_ctl[2];
      memread         <= m_ctl[1];
      memwrite        <= m_ctl[0];
      add_result      <= target_next;
      zero            <= (alu_next == '0);
      alu_result      <= alu_next;
      rdata2out       <= rt_val;
      five_bit_muxout <= dst_next;
    end
  end

endmodule
